// File: rtl/muxn_pipe_pkg.sv
// Shared constants, state encoding and select range check for muxn_pipe.
package muxn_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_N     = 4;

    // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/muxn_pipe_if.sv
// Producer/consumer handshake bundle for muxn_pipe.
interface muxn_pipe_if
    import muxn_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N     = DEF_N
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   sel;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [WIDTH-1:0]   out_data;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_err, out_valid
    );

endinterface

// File: rtl/muxn_pipe_skid_reg.sv
// Two-entry valid/ready register stage: output register plus one skid entry.
module muxn_pipe_skid_reg
    import muxn_pipe_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_flush,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic         r_out_valid;
    logic         r_skid_valid;
    logic [W-1:0] r_out_data;
    logic [W-1:0] r_skid_data;
    logic         w_acc;
    logic         w_drn;
    logic [1:0]   w_state;

    // Ready is a pure register decode so it never depends on i_ready.
    assign o_ready = !r_skid_valid && !rst;
    assign w_acc   = i_valid && o_ready && !i_flush;
    assign w_drn   = r_out_valid && i_ready;
    assign w_state = {r_out_valid, r_skid_valid};
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= i_data;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_drn) begin
                        r_out_data <= i_data;
                    end else if (w_acc) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= i_data;
                    end else if (w_drn) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_drn) begin
                        r_out_data   <= r_skid_data;
                        r_skid_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// N:1 operand selector with range check, registered through a 2-entry skid stage.
module muxn_pipe
    import muxn_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N     = DEF_N,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input logic        clk,
    input logic        rst,
    muxn_pipe_if.slave bus
);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_err;
    logic [WIDTH:0]   w_out;

    // Out-of-range selects match no channel and fall through to zero.
    always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_err = !sel_in_range(32'(bus.sel), N);

    muxn_pipe_skid_reg #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({w_err, w_sel_data}),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_flush (bus.flush),
        .o_data  (w_out),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready)
    );

    assign bus.out_err  = w_out[WIDTH];
    assign bus.out_data = w_out[WIDTH-1:0];

endmodule
